// File: rtl/simple_ask_uart_rx_pkg.sv
// Shared definitions for the simple ASK UART receiver: FSM states, frame size, idle line level
// and the 2-of-3 vote used when bit decisions are majority-filtered.
package simple_ask_uart_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_e;

   localparam int   UART_DATA_BITS = 8;
   localparam logic IDLE_LINE      = 1'b1;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/ask_uart_rx_fifo.sv
// First-word-fall-through byte FIFO, depth 2**RX_SIZE; head shows 0 while empty.
module ask_uart_rx_fifo
#(
   parameter int RX_SIZE = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [7:0] din,
   output logic       full,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       empty
);

   localparam int               DEPTH   = 1 << RX_SIZE;
   localparam logic [RX_SIZE:0] DEPTH_C = (RX_SIZE+1)'(DEPTH);

   logic [7:0]         mem [DEPTH];
   logic [RX_SIZE-1:0] wr_ptr, rd_ptr;
   logic [RX_SIZE:0]   count;
   logic               do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == DEPTH_C);
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? 8'h00 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/simple_ask_uart_rx.sv
// ASK UART receiver: slices 2-bit amplitude to a line bit, decodes 8N1 frames, buffers bytes on AXIS.
// Optional macro ASK_UART_RX_MAJORITY_EN: 2-of-3 vote around mid-bit, decision one cycle later.
module simple_ask_uart_rx
   import simple_ask_uart_rx_pkg::*;
#(
   parameter int         CLKDIV_RX  = 100,
   parameter logic [1:0] ASK_THRESH = 2'd1,
   parameter int         RX_SIZE    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] ask_rx,
   output logic [7:0] o_tdata,
   output logic       o_tvalid,
   input  logic       o_tready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int            CW   = $clog2(CLKDIV_RX);
   localparam logic [CW-1:0] MID  = CW'(CLKDIV_RX / 2);
   localparam logic [CW-1:0] LAST = CW'(CLKDIV_RX - 1);

   rx_state_e  state_q, state_d;
   logic       sync_p0, sync_p1, line_p2;
   logic [CW-1:0] cnt;
   logic [2:0] bit_idx;
   logic [7:0] shift_q;
   logic       fall, strobe, bit_val;
   logic       push_req, ferr_d;
   logic       fifo_push, fifo_full, fifo_empty;

   // Slicer + 2-FF synchroniser; line_p2 only serves start-edge detection.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_p0 <= IDLE_LINE;
         sync_p1 <= IDLE_LINE;
         line_p2 <= IDLE_LINE;
      end else begin
         sync_p0 <= (ask_rx >= ASK_THRESH);
         sync_p1 <= sync_p0;
         line_p2 <= sync_p1;
      end
   end

   assign fall = line_p2 & ~sync_p1;

`ifdef ASK_UART_RX_MAJORITY_EN
   localparam logic [CW-1:0] MID_M1 = CW'(CLKDIV_RX / 2 - 1);
   localparam logic [CW-1:0] DECIDE = CW'(CLKDIV_RX / 2 + 1);
   logic s_m1, s_mid;

   always_ff @(posedge clk) begin
      if (cnt == MID_M1) s_m1  <= sync_p1;
      if (cnt == MID)    s_mid <= sync_p1;
   end

   assign bit_val = maj3(s_m1, s_mid, sync_p1);
`else
   localparam logic [CW-1:0] DECIDE = MID;
   assign bit_val = sync_p1;
`endif

   assign strobe = (state_q != ST_IDLE) && (cnt == DECIDE);

   always_comb begin
      state_d  = state_q;
      push_req = 1'b0;
      ferr_d   = 1'b0;
      case (state_q)
         ST_IDLE:  if (fall) state_d = ST_START;
         ST_START: if (strobe) state_d = bit_val ? ST_IDLE : ST_DATA;
         ST_DATA:  if (strobe && (bit_idx == 3'(UART_DATA_BITS - 1))) state_d = ST_STOP;
         ST_STOP: begin
            if (strobe) begin
               state_d  = ST_IDLE;
               push_req = bit_val;
               ferr_d   = ~bit_val;
            end
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // Counter free-runs modulo CLKDIV_RX from the start edge, keeping every decision at mid-bit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state_q   <= state_d;
         frame_err <= ferr_d;
         overrun   <= push_req & ~fifo_push;
         if (state_q == ST_IDLE) begin
            cnt     <= '0;
            bit_idx <= '0;
         end else begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            if (state_q == ST_DATA && strobe) bit_idx <= bit_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == ST_DATA && strobe) shift_q <= {bit_val, shift_q[7:1]};
   end

   assign fifo_push = push_req & (~fifo_full | (o_tready & o_tvalid));
   assign o_tvalid  = ~fifo_empty;

   ask_uart_rx_fifo #(
      .RX_SIZE (RX_SIZE)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (shift_q),
      .full  (fifo_full),
      .pop   (o_tready),
      .dout  (o_tdata),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_simple_ask_uart_rx.sv
// Bench for simple_ask_uart_rx: bit-level ASK transmitter model, byte-queue reference model.
`timescale 1ns/1ps
module tb_simple_ask_uart_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] ask_rx = 2'd3;
   logic [7:0] o_tdata;
   logic       o_tvalid;
   logic       o_tready = 1'b0;
   logic       frame_err, overrun;

   int checks = 0;
   int errors = 0;

`ifdef ASK_UART_RX_MAJORITY_EN
   localparam int DEC_OFF = 55;
`else
   localparam int DEC_OFF = 54;
`endif

   // Reference model state
   logic [7:0] mdl_q[$];
   logic [7:0] got_q[$];
   logic [7:0] bp_bytes[$];
   bit         mdl_ready = 1'b0;
   int         mdl_fill  = 0;
   int         exp_ferr  = 0;
   int         exp_ovr   = 0;
   int         ferr_cnt  = 0;
   int         ovr_cnt   = 0;

   always #62.5 clk = ~clk;

   simple_ask_uart_rx #(
      .CLKDIV_RX  (100),
      .ASK_THRESH (2'd1),
      .RX_SIZE    (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ask_rx    (ask_rx),
      .o_tdata   (o_tdata),
      .o_tvalid  (o_tvalid),
      .o_tready  (o_tready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always @(negedge clk) begin
      if (o_tvalid === 1'b1 && o_tready === 1'b1) got_q.push_back(o_tdata);
      if (frame_err === 1'b1) ferr_cnt++;
      if (overrun === 1'b1) ovr_cnt++;
   end

   // A received frame: bad stop -> frame error; else delivered, held, or dropped when 16 are held.
   function automatic void mdl_rx(input logic [7:0] b, input logic stop_v);
      if (!stop_v) exp_ferr++;
      else if (mdl_ready) mdl_q.push_back(b);
      else if (mdl_fill < 16) begin
         mdl_q.push_back(b);
         mdl_fill++;
      end else exp_ovr++;
   endfunction

   // All drive tasks start and end just after a rising edge.
   task automatic drive_bit(input logic v, input int n);
      logic [1:0] lvl;
      lvl = v ? 2'($urandom_range(3, 1)) : 2'd0;
      for (int i = 0; i < n; i++) begin
         ask_rx = lvl;
         @(posedge clk); #1;
      end
   endtask

   task automatic send_head(input logic [7:0] b, input logic stop_v, input int stop_len);
      drive_bit(1'b0, 100);
      for (int i = 0; i < 8; i++) drive_bit(b[i], 100);
      drive_bit(stop_v, stop_len);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v);
      send_head(b, stop_v, 100);
      drive_bit(1'b1, $urandom_range(20, 2));
      mdl_rx(b, stop_v);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", o_tvalid); end
      checks++; if (o_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata: got %h expected 00", o_tdata); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
      rst = 1'b1;
      drive_bit(1'b1, 10);
   endtask

   task automatic test_loopback();
      logic [7:0] vec[$];
      vec = '{8'h55, 8'h00, 8'hAA, 8'hFF, 8'h53, 8'h18};
      for (int i = 0; i < 4; i++) vec.push_back(8'($urandom));
      o_tready = 1'b1; mdl_ready = 1'b1;
      foreach (vec[i]) send_frame(vec[i], 1'b1);
      checks++; if (got_q.size() !== mdl_q.size()) begin errors++; $display("FAIL loop_count: got %0d expected %0d", got_q.size(), mdl_q.size()); end
      else foreach (mdl_q[i]) begin
         checks++; if (got_q[i] !== mdl_q[i]) begin errors++; $display("FAIL loop_byte%0d: got %h expected %h", i, got_q[i], mdl_q[i]); end
      end
      checks++; if (ferr_cnt !== exp_ferr || ovr_cnt !== exp_ovr) begin errors++; $display("FAIL loop_pulses: got ferr=%0d ovr=%0d expected ferr=%0d ovr=%0d", ferr_cnt, ovr_cnt, exp_ferr, exp_ovr); end
      got_q.delete(); mdl_q.delete();
   endtask

   task automatic test_backpressure();
      logic [7:0] b;
      o_tready = 1'b0; mdl_ready = 1'b0; mdl_fill = 0;
      bp_bytes.delete();
      b = 8'($urandom);
      bp_bytes.push_back(b);
      send_head(b, 1'b1, DEC_OFF - 1);
      checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL lat_before: got tvalid %b expected 0", o_tvalid); end
      drive_bit(1'b1, 1);
      checks++; if (o_tvalid !== 1'b1 || o_tdata !== b) begin errors++; $display("FAIL lat_after: got tvalid %b data %h expected 1 %h", o_tvalid, o_tdata, b); end
      drive_bit(1'b1, 100 - DEC_OFF + 5);
      mdl_rx(b, 1'b1);
      for (int i = 1; i < 20; i++) begin
         b = 8'($urandom);
         bp_bytes.push_back(b);
         send_frame(b, 1'b1);
         checks++; if (o_tvalid !== 1'b1 || o_tdata !== bp_bytes[0]) begin errors++; $display("FAIL bp_hold%0d: got tvalid %b data %h expected 1 %h", i, o_tvalid, o_tdata, bp_bytes[0]); end
      end
      checks++; if (ovr_cnt !== exp_ovr) begin errors++; $display("FAIL bp_overrun: got %0d expected %0d", ovr_cnt, exp_ovr); end
      checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL bp_nopop: got %0d expected 0", got_q.size()); end
   endtask

   task automatic test_push_pop_full();
      logic [7:0] b;
      b = 8'($urandom);
      send_head(b, 1'b1, DEC_OFF - 1);
      o_tready = 1'b1;
      drive_bit(1'b1, 1);
      o_tready = 1'b0;
      drive_bit(1'b1, 100 - DEC_OFF + 5);
      mdl_fill--;
      mdl_rx(b, 1'b1);
      checks++; if (ovr_cnt !== exp_ovr) begin errors++; $display("FAIL ppf_overrun: got %0d expected %0d", ovr_cnt, exp_ovr); end
      checks++; if (o_tdata !== bp_bytes[1]) begin errors++; $display("FAIL ppf_head: got %h expected %h", o_tdata, bp_bytes[1]); end
      o_tready = 1'b1; mdl_ready = 1'b1; mdl_fill = 0;
      drive_bit(1'b1, 40);
      checks++; if (got_q.size() !== mdl_q.size()) begin errors++; $display("FAIL drain_count: got %0d expected %0d", got_q.size(), mdl_q.size()); end
      else foreach (mdl_q[i]) begin
         checks++; if (got_q[i] !== mdl_q[i]) begin errors++; $display("FAIL drain_byte%0d: got %h expected %h", i, got_q[i], mdl_q[i]); end
      end
      checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL drain_empty: got tvalid %b expected 0", o_tvalid); end
      got_q.delete(); mdl_q.delete();
   endtask

   task automatic test_framing();
      o_tready = 1'b1; mdl_ready = 1'b1;
      send_frame(8'hA5, 1'b0);
      checks++; if (ferr_cnt !== exp_ferr) begin errors++; $display("FAIL frame_err_count: got %0d expected %0d", ferr_cnt, exp_ferr); end
      checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL frame_nopush: got %0d expected 0", got_q.size()); end
      send_frame(8'h3C, 1'b1);
      checks++; if (got_q.size() !== 1 || got_q[0] !== 8'h3C) begin errors++; $display("FAIL frame_next: got %0d bytes expected 1 byte 3c", got_q.size()); end
      got_q.delete(); mdl_q.delete();
   endtask

   task automatic test_glitch();
      drive_bit(1'b0, 20);
      drive_bit(1'b1, 150);
      checks++; if (got_q.size() !== 0 || ferr_cnt !== exp_ferr || ovr_cnt !== exp_ovr) begin errors++; $display("FAIL glitch_idle: got bytes=%0d ferr=%0d ovr=%0d expected 0 %0d %0d", got_q.size(), ferr_cnt, ovr_cnt, exp_ferr, exp_ovr); end
`ifdef ASK_UART_RX_MAJORITY_EN
      drive_bit(1'b0, 100);
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            drive_bit(1'b1, 51); drive_bit(1'b0, 1); drive_bit(1'b1, 48);
         end else drive_bit(1'b1, 100);
      end
      drive_bit(1'b1, 110);
      mdl_rx(8'hFF, 1'b1);
      checks++; if (got_q.size() !== 1 || mdl_q.size() !== 1 || got_q[0] !== mdl_q[0]) begin errors++; $display("FAIL glitch_spike: got %0d bytes expected 1 byte ff", got_q.size()); end
      got_q.delete(); mdl_q.delete();
`endif
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] b;
      b = {4'hF, 4'($urandom)};
      drive_bit(1'b0, 100);
      for (int i = 0; i < 4; i++) drive_bit(b[i], 100);
      drive_bit(1'b1, 20);
      rst = 1'b0;
      drive_bit(1'b1, 3);
      rst = 1'b1;
      drive_bit(1'b1, 77);
      for (int i = 5; i < 8; i++) drive_bit(1'b1, 100);
      drive_bit(1'b1, 120);
      checks++; if (got_q.size() !== 0 || ferr_cnt !== exp_ferr || ovr_cnt !== exp_ovr) begin errors++; $display("FAIL rstmid_quiet: got bytes=%0d ferr=%0d ovr=%0d expected 0 %0d %0d", got_q.size(), ferr_cnt, ovr_cnt, exp_ferr, exp_ovr); end
      send_frame(8'h81, 1'b1);
      checks++; if (got_q.size() !== 1 || got_q[0] !== 8'h81) begin errors++; $display("FAIL rstmid_next: got %0d bytes expected 1 byte 81", got_q.size()); end
      got_q.delete(); mdl_q.delete();
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_backpressure();
      test_push_pop_full();
      test_framing();
      test_glitch();
      test_reset_mid_frame();
      checks++; if (ferr_cnt !== exp_ferr || ovr_cnt !== exp_ovr) begin errors++; $display("FAIL final_pulses: got ferr=%0d ovr=%0d expected ferr=%0d ovr=%0d", ferr_cnt, ovr_cnt, exp_ferr, exp_ovr); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
